// File: rtl/phtime_ctrl_pkg.sv
// Shared types and defaults for the phase-time multiplier sequencer.
// Holds the controller state enum, the default word widths and the requester-id width helper.
package phtime_ctrl_pkg;

    localparam int FWIDTH_DEF = 27;
    localparam int TWIDTH_DEF = 18;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        RUN,
        PEND
    } state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phtime_rr_arb.sv
// Round-robin arbiter: the first asserted req at or after the pointer wins.
// Latency: grant is combinational; the pointer moves past the winner on en & |req.
// Backpressure: grants nothing while en is low; requesters simply hold their req.
module phtime_rr_arb
    import phtime_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = id_width(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        gnt = (en && found) ? (NREQ'(1) << idx) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (en && |req)
            ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
    end

endmodule

// File: rtl/phtime_ctrl.sv
// Sequencer/arbiter sharing one freq x tcnt datapath between NREQ requesters.
// Latency: transfer in N -> LOAD in N+1 -> dp_freq/dp_tcnt=0/dp_reset low from N+2.
// Backpressure: req_ready only in IDLE/RUN; PHTIME_CTRL_WRAP_ALIGN_EN defers RUN loads to a tcnt wrap.
module phtime_ctrl
    import phtime_ctrl_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int FWIDTH   = FWIDTH_DEF,
    parameter int TWIDTH   = TWIDTH_DEF,
    parameter int PIPE_LAT = 4,
    parameter int TMO      = 8,
    parameter int IW       = id_width(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*FWIDTH-1:0] req_freq,
    output logic [NREQ-1:0]        req_ready,
    output logic [FWIDTH-1:0]      dp_freq,
    output logic [TWIDTH-1:0]      dp_tcnt,
    output logic                   dp_reset,
    input  logic                   dp_valid,
    output logic [IW-1:0]          active_id,
    output logic                   settled,
    output logic                   tmo_err
);

    // A timeout no longer than the pipeline would flag every healthy datapath.
    localparam int TMO_EFF = (TMO > PIPE_LAT) ? TMO : PIPE_LAT + 1;
    localparam int WCW     = $clog2(TMO_EFF);
    localparam logic [TWIDTH-1:0] TMAX = '1;

    state_t            state;
    logic [FWIDTH-1:0] pend_freq;
    logic [FWIDTH-1:0] sel_freq;
    logic [IW-1:0]     pend_id;
    logic [IW-1:0]     gnt_idx;
    logic [WCW-1:0]    wcnt;
    logic              grant_en;
    logic              xfer;
    logic              go_load;
    logic              go_pend;

    assign grant_en = !reset && (state == IDLE || state == RUN);
    assign xfer     = grant_en && |req_valid;
    assign sel_freq = req_freq[gnt_idx*FWIDTH +: FWIDTH];

    phtime_rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .en    (grant_en),
        .gnt   (req_ready),
        .idx   (gnt_idx)
    );

    always_comb begin
        go_load = 1'b0;
        go_pend = 1'b0;
        case (state)
            IDLE: go_load = xfer;
`ifdef PHTIME_CTRL_WRAP_ALIGN_EN
            // A transfer on the last tcnt already sits on the boundary.
            RUN: begin
                go_load = xfer && (dp_tcnt == TMAX);
                go_pend = xfer && (dp_tcnt != TMAX);
            end
            PEND: go_load = (dp_tcnt == TMAX);
`else
            RUN: go_load = xfer;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dp_freq   <= '0;
            dp_tcnt   <= '0;
            dp_reset  <= 1'b1;
            active_id <= '0;
            settled   <= 1'b0;
            tmo_err   <= 1'b0;
            pend_freq <= '0;
            pend_id   <= '0;
            wcnt      <= '0;
        end else begin
            if (xfer) begin
                pend_freq <= sel_freq;
                pend_id   <= gnt_idx;
            end
            case (state)
                IDLE: ;
                LOAD: begin
                    dp_freq   <= pend_freq;
                    active_id <= pend_id;
                    dp_reset  <= 1'b0;
                    dp_tcnt   <= '0;
                    wcnt      <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    dp_tcnt <= dp_tcnt + 1'b1;
                    if (dp_valid) begin
                        settled <= 1'b1;
                        state   <= RUN;
                    end else if (wcnt == WCW'(TMO_EFF - 1)) begin
                        // Run on regardless; settled stays low since the datapath never confirmed.
                        tmo_err <= 1'b1;
                        state   <= RUN;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                RUN, PEND: begin
                    dp_tcnt <= dp_tcnt + 1'b1;
                    if (!dp_valid) begin
                        settled <= 1'b0;
                        tmo_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (go_pend)
                state <= PEND;
            // Restart overrides the free-running count, including a wrap in the same cycle.
            if (go_load) begin
                state    <= LOAD;
                dp_reset <= 1'b1;
                dp_tcnt  <= '0;
                settled  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_phtime_ctrl.sv
// Bench for phtime_ctrl: timeline model of the expected outputs plus directed literal checks.
// The datapath is a PIPE_LAT-deep valid pipeline cleared by dp_reset; dp_kill holds its valid low.
module tb_phtime_ctrl;

    localparam int NREQ = 4;
    localparam int FW   = 27;
    localparam int TW   = 10;
    localparam int PL   = 4;
    localparam int TMO  = 8;
    localparam int IW   = 2;
    localparam int M    = 1 << TW;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*FW-1:0]   req_freq = '0;
    logic [NREQ-1:0]      req_ready;
    logic [FW-1:0]        dp_freq;
    logic [TW-1:0]        dp_tcnt;
    logic                 dp_reset;
    logic                 dp_valid;
    logic [IW-1:0]        active_id;
    logic                 settled;
    logic                 tmo_err;
    logic [PL-1:0]        sr = '0;
    logic                 dp_kill = 1'b0;
    int                   checks = 0;
    int                   failures = 0;

    phtime_ctrl #(
        .NREQ(NREQ), .FWIDTH(FW), .TWIDTH(TW), .PIPE_LAT(PL), .TMO(TMO)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_freq(req_freq),
        .req_ready(req_ready), .dp_freq(dp_freq), .dp_tcnt(dp_tcnt), .dp_reset(dp_reset),
        .dp_valid(dp_valid), .active_id(active_id), .settled(settled), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) sr <= dp_reset ? '0 : {sr[PL-2:0], 1'b1};
    assign dp_valid = sr[PL-1] && !dp_kill;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: everything is derived from the cycle of the last effective load request (xn).
    int              cyc = 0;
    int              xn = 0;
    int              xid = 0, previd = 0, pid = 0, ptr = 0;
    bit              have = 0, waiting = 0, pend = 0, set_e = 0, tmo_e = 0;
    logic [FW-1:0]   xfreq = '0, prevf = '0, pfreq = '0;

    always @(negedge clk) begin : model
        bit              en_e, in_run, loaded, rst_e;
        int              g, tc, ie;
        logic [FW-1:0]   fe;
        logic [NREQ-1:0] gv;
        if (reset) begin
            have = 0; waiting = 0; pend = 0; ptr = 0; set_e = 0; tmo_e = 0;
            prevf = '0; previd = 0; cyc = 0;
            chk("rst_dp_reset", dp_reset, 1);
            chk("rst_ready", req_ready, 0);
            chk("rst_freq", dp_freq, 0);
            chk("rst_tcnt", dp_tcnt, 0);
            chk("rst_settled", settled, 0);
            chk("rst_tmo", tmo_err, 0);
            chk("rst_id", active_id, 0);
        end else begin
            in_run = have && !waiting;
            en_e   = (!have || in_run) && !pend;
            g = -1;
            if (en_e)
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && req_valid[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
            gv     = (g >= 0) ? (NREQ'(1) << g) : '0;
            loaded = have && (cyc >= xn + 2);
            fe     = loaded ? xfreq : prevf;
            ie     = loaded ? xid : previd;
            tc     = loaded ? (cyc - xn - 2) % M : 0;
            rst_e  = !have || (cyc == xn + 1);
            chk("m_ready", req_ready, gv);
            chk("m_freq", dp_freq, fe);
            chk("m_id", active_id, ie);
            chk("m_tcnt", dp_tcnt, tc);
            chk("m_dp_reset", dp_reset, rst_e);
            chk("m_settled", settled, set_e);
            chk("m_tmo", tmo_err, tmo_e);
            if (waiting && loaded) begin
                if (dp_valid) begin
                    waiting = 0; set_e = 1;
                end else if (cyc == xn + 2 + TMO - 1) begin
                    waiting = 0; tmo_e = 1;
                end
            end else if (in_run && !dp_valid) begin
                set_e = 0; tmo_e = 1;
            end
            if (g >= 0) begin
                ptr = (g + 1) % NREQ;
`ifdef PHTIME_CTRL_WRAP_ALIGN_EN
                if (in_run && tc != M - 1) begin
                    pend = 1; pfreq = req_freq[g*FW +: FW]; pid = g;
                end else
`endif
                begin
                    prevf = fe; previd = ie; xn = cyc; xfreq = req_freq[g*FW +: FW];
                    xid = g; have = 1; waiting = 1; set_e = 0;
                end
            end
`ifdef PHTIME_CTRL_WRAP_ALIGN_EN
            else if (pend && tc == M - 1) begin
                prevf = fe; previd = ie; xn = cyc; xfreq = pfreq; xid = pid;
                pend = 0; waiting = 1; set_e = 0;
            end
`endif
            cyc++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        req_valid = '0;
        dp_kill   = 1'b0;
        reset     = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic wait_grant(output int idx, output int n);
        idx = -1;
        n   = 0;
        while (idx < 0 && n < 3000) begin
            #1;
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i] && req_valid[i]) idx = i;
            if (idx < 0) begin
                tick();
                n++;
            end
        end
        if (idx < 0) chk("grant_timeout", 0, 1);
    endtask

    task automatic wait_tcnt(input int v);
        int n = 0;
        while (dp_tcnt != TW'(v) && n < 3 * M) begin
            tick();
            n++;
        end
        if (n >= 3 * M) chk("tcnt_wait_timeout", 0, 1);
    endtask

    // Lone request from IDLE (or on the last tcnt of RUN): full load/settle timeline.
    task automatic single_req(input int id, input logic [FW-1:0] f);
        req_freq[id*FW +: FW] = f;
        req_valid = NREQ'(1) << id;
        #1 chk("sr_ready", req_ready, NREQ'(1) << id);
        tick();
        req_valid = '0;
        chk("sr_load_reset", dp_reset, 1);
        chk("sr_load_tcnt", dp_tcnt, 0);
        tick();
        chk("sr_freq", dp_freq, f);
        chk("sr_id", active_id, id);
        chk("sr_dp_reset_low", dp_reset, 0);
        chk("sr_tcnt0", dp_tcnt, 0);
        tick(4);
        chk("sr_settled_early", settled, 0);
        tick();
        chk("sr_settled", settled, 1);
    endtask

    initial begin : stim
        int idx, n;
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        tick(3);
        reset = 1'b0;
        tick(2);

        single_req(2, 27'h0123456);

        wait_tcnt(M - 1);
        chk("wrap_settled_top", settled, 1);
        tick();
        chk("wrap_tcnt0", dp_tcnt, 0);
        chk("wrap_no_reset", dp_reset, 0);
        chk("wrap_settled", settled, 1);
        wait_tcnt(M - 1);
        single_req(1, 27'h7abcdef);

`ifdef PHTIME_CTRL_WRAP_ALIGN_EN
        wait_tcnt(100);
        req_freq[3*FW +: FW] = 27'h0055aa1;
        req_valid = 4'b1000;
        #1 chk("al_ready", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        chk("al_freq_held", dp_freq, 27'h7abcdef);
        chk("al_settled_held", settled, 1);
        wait_tcnt(M - 1);
        chk("al_freq_top", dp_freq, 27'h7abcdef);
        chk("al_settled_top", settled, 1);
        tick();
        chk("al_load_reset", dp_reset, 1);
        tick();
        chk("al_freq_new", dp_freq, 27'h0055aa1);
        tick(6);
`endif

        do_reset();
        for (int i = 0; i < NREQ; i++) req_freq[i*FW +: FW] = FW'(32'h100 + i);
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(idx, n);
            chk("rr_order", idx, exp_ord[i]);
`ifndef PHTIME_CTRL_WRAP_ALIGN_EN
            if (i > 0) chk("rr_gap", n, 6);
`endif
            tick();
        end
        req_valid = '0;
        tick(8);

        do_reset();
        dp_kill = 1'b1;
        req_valid = 4'b1000;
        wait_grant(idx, n);
        tick();
        req_valid = '0;
        tick(1 + TMO - 1);
        chk("tmo_not_yet", tmo_err, 0);
        tick();
        chk("tmo_set", tmo_err, 1);
        chk("tmo_settled", settled, 0);
        req_valid = 4'b0001;
        #1 chk("tmo_run_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        dp_kill = 1'b0;
        tick(12);
        chk("tmo_sticky", tmo_err, 1);
        chk("tmo_new_settled", settled, 1);
        do_reset();
        chk("tmo_cleared", tmo_err, 0);

        req_valid = 4'b0001;
        wait_grant(idx, n);
        tick();
        req_valid = '0;
        tick(2);
        #2 reset = 1'b1;
        #1;
        chk("ar_dp_reset", dp_reset, 1);
        chk("ar_freq", dp_freq, 0);
        chk("ar_settled", settled, 0);
        chk("ar_tcnt", dp_tcnt, 0);
        tick();
        reset = 1'b0;
        tick();
        req_valid = 4'b0010;
        wait_grant(idx, n);
        tick();
        req_valid = '0;
        #2 reset = 1'b1;
        #1 chk("ar_load_dp_reset", dp_reset, 1);
        tick();
        reset = 1'b0;
        tick(2);
        single_req(3, 27'h4000001);
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phtime_ctrl.md
Name: phtime_ctrl

Overview:
- Sequencer and arbiter for the phase-time multiplier datapath (freq × tcnt, 4-cycle pipeline, synchronous datapath reset).
- Shares one datapath between NREQ frequency requesters using round-robin arbitration.
- For each granted request it drives freq, a free-running tcnt and a datapath reset pulse, then tracks the datapath valid to report when the new frequency is live.

Parameters:
- NREQ, 4, number of frequency requesters.
- FWIDTH, 27, frequency/phase word width.
- TWIDTH, 18, tcnt width (at most 18, to fit the DSP).
- PIPE_LAT, 4, cycles from dp_reset deassert to dp_valid rise.
- TMO, 8, WAIT-state timeout in cycles (must be greater than PIPE_LAT).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester frequency-update request.
- req_freq  in  NREQ*FWIDTH  packed request frequencies; requester i occupies bits [i*FWIDTH +: FWIDTH].
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- dp_freq  out  FWIDTH  frequency to the datapath.
- dp_tcnt  out  TWIDTH  time count to the datapath.
- dp_reset  out  1  synchronous reset to the datapath.
- dp_valid  in  1  valid returned by the datapath.
- active_id  out  clog2(NREQ)  index of the requester owning dp_freq.
- settled  out  1  datapath output reflects dp_freq.
- tmo_err  out  1  sticky flag: dp_valid did not arrive within TMO.

Behaviour:
- Reset values (asynchronous): state=IDLE, dp_freq=0, dp_tcnt=0, dp_reset=1, active_id=0, settled=0, tmo_err=0, round-robin pointer=0, req_ready=0.
- States:
  - IDLE: dp_reset=1, tcnt held at 0. Grant enabled. On a transfer go to LOAD.
  - LOAD: exactly 1 cycle. Register dp_freq and active_id, dp_reset=1, tcnt=0. Go to WAIT.
  - WAIT: dp_reset=0, tcnt increments each cycle, grants disabled, wait counter runs. On dp_valid=1 go to RUN. If the counter reaches TMO first, set tmo_err and go to RUN anyway.
  - RUN: settled=1, tcnt increments and wraps from 2^TWIDTH-1 to 0 with no stall. Grant enabled. On a transfer: settled=0, go to LOAD.
- Grant:
  - Combinational. The first req_valid at or after the pointer, searching circularly, receives req_ready, and only in IDLE or RUN.
  - After each transfer the pointer becomes the granted index + 1 (mod NREQ).
  - req_ready is never asserted for an invalid requester.
  - A requester drives req_freq stable while its req_valid is high.
- Latency:
  - Transfer in cycle N gives LOAD in N+1; dp_freq is valid from N+2.
  - dp_reset is low from N+2 and dp_tcnt=0 in N+2.
  - With a nominal datapath, dp_valid rises at N+2+PIPE_LAT and settled rises 1 cycle later.
- Boundaries:
  - Simultaneous requests: only one is granted per cycle; the others wait.
  - Request in the same cycle as a tcnt wrap: the request is granted and the wrap is discarded by LOAD.
  - dp_valid dropping in RUN: settled=0 and a new WAIT is not entered. This is an error; tmo_err is set.
  - tmo_err clears only on reset.
  - reset asserted mid-WAIT or mid-LOAD: immediate return to IDLE with reset values.

Optional Feature:
- Macro: PHTIME_CTRL_WRAP_ALIGN_EN.
- When defined:
  - A RUN-state transfer goes to a PEND state: settled stays 1, the new frequency is held in a pending register, and grants are disabled.
  - LOAD is entered in the cycle after dp_tcnt==2^TWIDTH-1, so the datapath restarts on a tcnt boundary.
  - A transfer from IDLE goes directly to LOAD.
- When undefined: no PEND state; behaviour is as above.

Decomposition:
- Package phtime_ctrl_pkg holds:
  - the state enum (IDLE, LOAD, WAIT, RUN, PEND);
  - the FWIDTH and TWIDTH defaults;
  - the id-width function (clog2).
- One sub-module, phtime_rr_arb: NREQ-wide round-robin arbiter with inputs req and en, outputs one-hot gnt and index; the pointer updates on en & |req.

Test Plan:
- Single request after reset: req_valid[2]=1, req_freq[2]=27'h0123456 in cycle 5 → req_ready[2]=1 in cycle 5; dp_freq=27'h0123456 and active_id=2 from cycle 7; dp_reset low from cycle 7; settled=1 at cycle 12 with a nominal 4-cycle datapath model.
- All four requesters valid continuously → grants in order 0,1,2,3,0, each grant separated by the LOAD+WAIT+RUN sequence; no requester is granted twice before the others.
- tcnt wrap: one request, then hold in RUN for 2^18+10 cycles → dp_tcnt passes 262143 then 0, settled stays 1, no dp_reset pulse.
- Timeout: datapath model never raises dp_valid → tmo_err=1 exactly TMO cycles after entering WAIT, state=RUN; tmo_err stays 1 until reset.
- Asynchronous reset mid-WAIT: assert reset between clock edges → dp_reset=1, dp_freq=0, settled=0, state=IDLE immediately; next request proceeds normally.
- With PHTIME_CTRL_WRAP_ALIGN_EN: request at tcnt=100 in RUN → dp_freq unchanged and settled=1 until tcnt=262143; LOAD in the following cycle.
